// File: rtl/apb_timer_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Define APB_TIMER_ARB_TIMEOUT_EN to abort ACCESS after 16 stalled cycles.
module apb_timer_arbiter #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  preset,
    input  logic                  r0_req,
    input  logic                  r1_req,
    input  logic                  r0_write,
    input  logic                  r1_write,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic [1:0]            done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t                state, state_n;
    logic                  last_grant, last_grant_n;
    logic                  pick;
    logic [1:0]            done_n;
    logic [DATA_WIDTH-1:0] rdata_n;
    logic                  err_n;
    logic [ADDR_WIDTH-1:0] paddr_n;
    logic                  pwrite_n;
    logic                  psel_n;
    logic                  penable_n;
    logic [DATA_WIDTH-1:0] pwdata_n;
`ifdef APB_TIMER_ARB_TIMEOUT_EN
    logic [3:0]            wait_cnt, wait_cnt_n;
`endif

    // last_grant doubles as the owner of the transfer in flight
    always_comb begin
        pick = 1'b0;
        if (r0_req && r1_req) begin
            pick = ~last_grant;
        end else if (r1_req) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        done_n       = 2'b00;
        rdata_n      = rdata;
        err_n        = err;
        paddr_n      = paddr;
        pwrite_n     = pwrite;
        psel_n       = psel;
        penable_n    = penable;
        pwdata_n     = pwdata;
`ifdef APB_TIMER_ARB_TIMEOUT_EN
        wait_cnt_n   = wait_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    state_n      = SETUP;
                    last_grant_n = pick;
                    paddr_n      = pick ? r1_addr : r0_addr;
                    pwrite_n     = pick ? r1_write : r0_write;
                    pwdata_n     = pick ? r1_wdata : r0_wdata;
                    psel_n       = 1'b1;
                    penable_n    = 1'b0;
                end
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
`ifdef APB_TIMER_ARB_TIMEOUT_EN
                wait_cnt_n = 4'd0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    state_n   = DONE;
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    err_n     = pslverr;
                    done_n    = last_grant ? 2'b10 : 2'b01;
                    if (!pwrite) begin
                        rdata_n = prdata;
                    end
                end
`ifdef APB_TIMER_ARB_TIMEOUT_EN
                else if (wait_cnt == 4'd15) begin
                    state_n   = DONE;
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    err_n     = 1'b1;
                    rdata_n   = '0;
                    done_n    = last_grant ? 2'b10 : 2'b01;
                end else begin
                    wait_cnt_n = wait_cnt + 4'd1;
                end
`endif
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            done       <= 2'b00;
            rdata      <= '0;
            err        <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwdata     <= '0;
`ifdef APB_TIMER_ARB_TIMEOUT_EN
            wait_cnt   <= 4'd0;
`endif
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            done       <= done_n;
            rdata      <= rdata_n;
            err        <= err_n;
            paddr      <= paddr_n;
            pwrite     <= pwrite_n;
            psel       <= psel_n;
            penable    <= penable_n;
            pwdata     <= pwdata_n;
`ifdef APB_TIMER_ARB_TIMEOUT_EN
            wait_cnt   <= wait_cnt_n;
`endif
        end
    end

endmodule
